argmax_stream_driver: RTL and testbench

- Driving end of the argmax-cell stream protocol: buffers CELL_AMOUNT class scores from the output layer and replays them as index/value/enable beats.
- Captures the tagged result word the argmax cell returns and presents the winning class index on a valid/ready port.
- Sits between the final dense-layer accumulators and the classification output.

---
 rtl/argmax_stream_driver.sv | 196 +++++++++++++++++++
 tb/tb_argmax_stream_driver.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_stream_driver.sv
// argmax_stream_driver
//   Driving end of the argmax-cell stream protocol. Buffers CELL_AMOUNT
//   unsigned class scores and replays them to the argmax cell as
//   index/value/enable beats. It then captures the tagged result word and
//   presents the winning class index on a valid/ready port.
//
//   The cell re-seeds its best value on index 0 and has no reset of its own.
//   For that reason a frame is always streamed starting from index 0.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   score_in     class score, arrives in class order 0..CELL_AMOUNT-1
//   score_valid  score_in valid
//   score_ready  scores accepted (high only while loading)
//   cell_index   index beat to the argmax cell (zero-extended)
//   cell_value   value beat to the argmax cell
//   cell_enable  beat valid
//   cell_result  {done tag, winning index} from the argmax cell
//   class_out    captured winning index (0 on timeout)
//   class_valid  class_out valid
//   class_ready  consumer accepts class_out
//   busy         frame in progress (anything but an empty LOAD)
//   error        sticky result-timeout flag, cleared only by reset
//
// State  | meaning
// S_LOAD   | accepting scores into the buffer
// S_STREAM | replaying buffered scores to the cell, one beat per cycle
// S_WAIT   | waiting for the cell's tagged result (with timeout)
// S_HOLD   | presenting class_out until the consumer takes it
module argmax_stream_driver #(
  parameter int DATA_WIDTH     = 32,
  parameter int CELL_AMOUNT    = 4,
  parameter int RESULT_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] score_in,
  input  logic                  score_valid,
  output logic                  score_ready,
  output logic [DATA_WIDTH-1:0] cell_index,
  output logic [DATA_WIDTH-1:0] cell_value,
  output logic                  cell_enable,
  input  logic [DATA_WIDTH:0]   cell_result,
  output logic [DATA_WIDTH-1:0] class_out,
  output logic                  class_valid,
  input  logic                  class_ready,
  output logic                  busy,
  output logic                  error
);

  localparam int CW = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
  localparam int TW = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(CELL_AMOUNT - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(RESULT_TIMEOUT);

  typedef enum logic [1:0] {
    S_LOAD,
    S_STREAM,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         load_cnt_q, load_cnt_d;
  logic [CW-1:0]         stream_cnt_q, stream_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0] cell_value_q, cell_value_d;
  logic                  cell_enable_q, cell_enable_d;
  logic [DATA_WIDTH-1:0] class_out_q, class_out_d;
  logic                  class_valid_q, class_valid_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] score_buf_q [CELL_AMOUNT];
  logic                  buf_we;
  logic [CW-1:0]         stream_next;
  logic [TW-1:0]         to_next;

  assign stream_next = stream_cnt_q + CW'(1);
  assign to_next     = to_cnt_q + TW'(1);

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    stream_cnt_d  = stream_cnt_q;
    to_cnt_d      = to_cnt_q;
    cell_value_d  = cell_value_q;
    cell_enable_d = 1'b0;
    class_out_d   = class_out_q;
    class_valid_d = class_valid_q;
    error_d       = error_q;
    buf_we        = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (score_valid) begin
          buf_we = 1'b1;
          if (load_cnt_q == LAST_IDX) begin
            // Beat 0 goes out on the cycle right after the last load.
            // Slot 0 was written on an earlier edge because CELL_AMOUNT >= 2.
            load_cnt_d    = '0;
            stream_cnt_d  = '0;
            cell_enable_d = 1'b1;
            cell_value_d  = score_buf_q[0];
            state_d       = S_STREAM;
          end else begin
            load_cnt_d = load_cnt_q + CW'(1);
          end
        end
      end

      S_STREAM: begin
        if (stream_cnt_q == LAST_IDX) begin
          stream_cnt_d = '0;
          to_cnt_d     = '0;
          state_d      = S_WAIT;
        end else begin
          cell_enable_d = 1'b1;
          stream_cnt_d  = stream_next;
          cell_value_d  = score_buf_q[stream_next];
        end
      end

      S_WAIT: begin
        if (cell_result[DATA_WIDTH]) begin
          class_out_d   = cell_result[DATA_WIDTH-1:0];
          class_valid_d = 1'b1;
          state_d       = S_HOLD;
        end else if (to_next == TO_LIMIT) begin
          // Still finish the frame so the consumer never stalls on a dead cell.
          error_d       = 1'b1;
          class_out_d   = '0;
          class_valid_d = 1'b1;
          state_d       = S_HOLD;
        end else begin
          to_cnt_d = to_next;
        end
      end

      S_HOLD: begin
        if (class_ready) begin
          class_valid_d = 1'b0;
          state_d       = S_LOAD;
        end
      end

      default: state_d = S_LOAD;
    endcase

    busy_d = !((state_d == S_LOAD) && (load_cnt_d == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_LOAD;
      load_cnt_q    <= '0;
      stream_cnt_q  <= '0;
      to_cnt_q      <= '0;
      cell_value_q  <= '0;
      cell_enable_q <= 1'b0;
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      stream_cnt_q  <= stream_cnt_d;
      to_cnt_q      <= to_cnt_d;
      cell_value_q  <= cell_value_d;
      cell_enable_q <= cell_enable_d;
      class_out_q   <= class_out_d;
      class_valid_q <= class_valid_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  // Buffer contents after reset are don't-care, so the buffer has no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      score_buf_q[load_cnt_q] <= score_in;
    end
  end

  assign score_ready = (state_q == S_LOAD);
  assign cell_index  = DATA_WIDTH'(stream_cnt_q);
  assign cell_value  = cell_value_q;
  assign cell_enable = cell_enable_q;
  assign class_out   = class_out_q;
  assign class_valid = class_valid_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule

// File: tb/tb_argmax_stream_driver.sv
// Directed testbench for argmax_stream_driver with a behavioural argmax cell:
// re-seed on index 0, ties to the higher index, and a done tag for one cycle
// after the last beat.
module tb_argmax_stream_driver;

  localparam int DW = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] score_in;
  logic          score_valid;
  logic          score_ready;
  logic [DW-1:0] cell_index;
  logic [DW-1:0] cell_value;
  logic          cell_enable;
  logic [DW:0]   cell_result;
  logic [DW-1:0] class_out;
  logic          class_valid;
  logic          class_ready;
  logic          busy;
  logic          error;

  int n_vec = 0;
  int n_err = 0;

  // Argmax cell model. Its state is deliberately never reset.
  logic          cell_attached = 1'b1;
  logic [DW-1:0] best_val = '0;
  logic [DW-1:0] best_idx = '0;
  logic          done_tag = 1'b0;

  always @(posedge clk) begin
    if (cell_enable) begin
      if (cell_index == 0 || cell_value >= best_val) begin
        best_val <= cell_value;
        best_idx <= cell_index;
      end
    end
    done_tag <= cell_enable && (cell_index == NC - 1);
  end

  assign cell_result = cell_attached ? {done_tag, best_idx} : '0;

  argmax_stream_driver #(
    .DATA_WIDTH(DW),
    .CELL_AMOUNT(NC),
    .RESULT_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .score_in(score_in),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .cell_index(cell_index),
    .cell_value(cell_value),
    .cell_enable(cell_enable),
    .cell_result(cell_result),
    .class_out(class_out),
    .class_valid(class_valid),
    .class_ready(class_ready),
    .busy(busy),
    .error(error)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back load; on return the DUT is one cycle past the last load.
  task automatic load_scores(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                             input logic [DW-1:0] s2, input logic [DW-1:0] s3);
    logic [DW-1:0] s [NC];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < NC; i++) begin
      score_valid = 1'b1;
      score_in    = s[i];
      step();
    end
    score_valid = 1'b0;
  endtask

  // lat = cycles since the last accepted score when class_valid is seen.
  task automatic wait_class(output int lat, output bit expired);
    lat = 1;
    while (class_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    expired = (class_valid !== 1'b1);
  endtask

  task automatic accept_class();
    class_ready = 1'b1;
    step();
    class_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_vec++;
    if (score_ready !== 1'b1 || cell_enable !== 1'b0 || cell_index !== '0 ||
        cell_value !== '0 || class_out !== '0 || class_valid !== 1'b0 ||
        error !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b en=%b idx=%0d val=%0d cls=%0d cv=%b err=%b busy=%b, want 1 0 0 0 0 0 0 0",
               score_ready, cell_enable, cell_index, cell_value, class_out,
               class_valid, error, busy);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_frame();
    logic [DW-1:0] exp_val [NC];
    exp_val[0] = 5; exp_val[1] = 9; exp_val[2] = 3; exp_val[3] = 7;
    load_scores(5, 9, 3, 7);
    for (int k = 0; k < NC; k++) begin
      n_vec++;
      if (cell_enable !== 1'b1 || cell_index !== DW'(k) || cell_value !== exp_val[k] ||
          score_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL beat%0d: en=%b idx=%0d val=%0d rdy=%b busy=%b, want 1 %0d %0d 0 1",
                 k, cell_enable, cell_index, cell_value, score_ready, busy, k, exp_val[k]);
      end
      step();
    end
    n_vec++;
    if (cell_enable !== 1'b0 || class_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wait_entry: en=%b cv=%b, want 0 0", cell_enable, class_valid);
    end
    step();
    n_vec++;
    if (class_valid !== 1'b1 || class_out !== 1 || error !== 1'b0) begin
      n_err++;
      $display("FAIL latency6: cv=%b cls=%0d err=%b, want 1 1 0", class_valid, class_out, error);
    end
    accept_class();
    n_vec++;
    if (class_valid !== 1'b0 || score_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL release: cv=%b rdy=%b busy=%b, want 0 1 0", class_valid, score_ready, busy);
    end
  endtask

  task automatic test_ties();
    int lat;
    bit expired;
    load_scores(8, 2, 8, 1);
    wait_class(lat, expired);
    n_vec++;
    if (expired || class_out !== 2 || lat != NC + 2) begin
      n_err++;
      $display("FAIL tie_high: cls=%0d lat=%0d expired=%b, want 2 6 0", class_out, lat, expired);
    end
    accept_class();
    load_scores(0, 0, 0, 0);
    wait_class(lat, expired);
    n_vec++;
    if (expired || class_out !== 3) begin
      n_err++;
      $display("FAIL all_zero: cls=%0d expired=%b, want 3 0", class_out, expired);
    end
    accept_class();
  endtask

  task automatic test_hold();
    int lat;
    bit expired;
    load_scores(6, 1, 9, 2);
    wait_class(lat, expired);
    n_vec++;
    if (expired || class_out !== 2) begin
      n_err++;
      $display("FAIL hold_first: cls=%0d expired=%b, want 2 0", class_out, expired);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (class_valid !== 1'b1 || class_out !== 2 || score_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: cv=%b cls=%0d rdy=%b, want 1 2 0",
                 i, class_valid, class_out, score_ready);
      end
    end
    accept_class();
    n_vec++;
    if (class_valid !== 1'b0 || score_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release: cv=%b rdy=%b, want 0 1", class_valid, score_ready);
    end
    // class_ready with nothing valid must not disturb the next frame.
    class_ready = 1'b1;
    load_scores(1, 2, 3, 4);
    class_ready = 1'b0;
    wait_class(lat, expired);
    n_vec++;
    if (expired || class_out !== 3) begin
      n_err++;
      $display("FAIL second_frame: cls=%0d expired=%b, want 3 0", class_out, expired);
    end
    accept_class();
  endtask

  task automatic test_gaps();
    logic [DW-1:0] s [NC];
    int lat;
    bit expired;
    s[0] = 3; s[1] = 8; s[2] = 1; s[3] = 2;
    for (int i = 0; i < NC; i++) begin
      score_valid = 1'b1;
      score_in    = s[i];
      step();
      if (i == 0) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_partial: busy=%b, want 1", busy);
        end
      end
      if (i < NC - 1) begin
        score_valid = 1'b0;
        score_in    = 32'hDEAD;
        step();
      end
    end
    // Keep offering a junk score through streaming; it must not be taken.
    score_valid = 1'b1;
    score_in    = 99;
    for (int k = 0; k < NC; k++) begin
      n_vec++;
      if (cell_enable !== 1'b1 || cell_index !== DW'(k) || cell_value !== s[k]) begin
        n_err++;
        $display("FAIL gap_beat%0d: en=%b idx=%0d val=%0d, want 1 %0d %0d",
                 k, cell_enable, cell_index, cell_value, k, s[k]);
      end
      step();
    end
    wait_class(lat, expired);
    n_vec++;
    if (expired || class_out !== 1 || score_ready !== 1'b0) begin
      n_err++;
      $display("FAIL gap_result: cls=%0d rdy=%b expired=%b, want 1 0 0", class_out, score_ready, expired);
    end
    score_valid = 1'b0;
    accept_class();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL gap_no_extra: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int lat;
    bit expired;
    cell_attached = 1'b0;
    load_scores(5, 9, 3, 7);
    wait_class(lat, expired);
    n_vec++;
    if (expired || error !== 1'b1 || class_out !== 0 || lat != NC + 1 + 4) begin
      n_err++;
      $display("FAIL timeout: err=%b cls=%0d lat=%0d expired=%b, want 1 0 9 0",
               error, class_out, lat, expired);
    end
    accept_class();
    cell_attached = 1'b1;
    load_scores(1, 2, 3, 4);
    wait_class(lat, expired);
    n_vec++;
    if (expired || error !== 1'b1 || class_out !== 3) begin
      n_err++;
      $display("FAIL error_sticky: err=%b cls=%0d expired=%b, want 1 3 0", error, class_out, expired);
    end
    accept_class();
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    bit expired;
    load_scores(100, 200, 50, 10);
    step();
    step();
    n_vec++;
    if (cell_index !== 2 || cell_enable !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_beat: idx=%0d en=%b, want 2 1", cell_index, cell_enable);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (cell_enable !== 1'b0 || score_ready !== 1'b1 || class_valid !== 1'b0 || error !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: en=%b rdy=%b cv=%b err=%b, want 0 1 0 0",
               cell_enable, score_ready, class_valid, error);
    end
    step();
    reset = 1'b0;
    step();
    load_scores(4, 1, 6, 2);
    wait_class(lat, expired);
    n_vec++;
    if (expired || class_out !== 2 || error !== 1'b0) begin
      n_err++;
      $display("FAIL reseed: cls=%0d err=%b expired=%b, want 2 0 0", class_out, error, expired);
    end
    accept_class();
  endtask

  initial begin
    reset       = 1'b1;
    score_in    = '0;
    score_valid = 1'b0;
    class_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_ties();
    test_hold();
    test_gaps();
    test_timeout();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
